// File: rtl/seq_detector_param_pkg.sv
// Shared types and constants for the parametrised serial-pattern detector.
// Holds the fill FSM encoding, legal pattern-length range and fill-counter sizing.
package seq_detector_param_pkg;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFilling = 2'd1,
        StArmed   = 2'd2
    } fill_state_e;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 16;

    // Width needed to hold fill values 0..pat_len-1.
    function automatic int unsigned fill_width(input int unsigned pat_len);
        return (pat_len < 2) ? 1 : $clog2(pat_len);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/data bundle between a serial-bit source and the pattern detector.
// The master drives pattern load, data and clear; the slave returns match status.
interface seq_detector_param_if #(
    parameter int unsigned PAT_LEN = 3,
    parameter int unsigned CNT_W   = 8
);

    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               in_valid;
    logic               data_in;
    logic               cnt_clr;
    logic               match;
    logic               match_r;
    logic [CNT_W-1:0]   match_count;
    logic               armed;

    modport master (
        output pat_load, pat_in, in_valid, data_in, cnt_clr,
        input  match, match_r, match_count, armed
    );

    modport slave (
        input  pat_load, pat_in, in_valid, data_in, cnt_clr,
        output match, match_r, match_count, armed
    );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    localparam logic [Width-1:0] CntMax = '1;

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CntMax)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Mealy detector for a run-time loadable PAT_LEN-bit pattern on a qualified serial stream,
// with optional overlap, registered match strobe and saturating match counter.
module seq_detector_param #(
    parameter int unsigned        PAT_LEN = 3,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [PAT_LEN-1:0] RST_PAT = {{(PAT_LEN-1){1'b1}}, 1'b0}
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);

    import seq_detector_param_pkg::*;

    localparam int unsigned        HistW    = PAT_LEN - 1;
    localparam int unsigned        FillW    = fill_width(PAT_LEN);
    localparam logic [FillW-1:0]   FillFull = FillW'(PAT_LEN - 1);

    if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN outside supported range");
    end

    logic [PAT_LEN-1:0] pat_d, pat_q;
    logic [HistW-1:0]   hist_d, hist_q;
    logic [FillW-1:0]   fill_d, fill_q;
    fill_state_e        state_d, state_q;
    logic               match_r_q;
    logic               match;
    logic [PAT_LEN-1:0] window;

    // Current history plus the bit on the wire forms the candidate word.
    assign window = {hist_q, bus.data_in};

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        match  = bus.in_valid && (state_q == StArmed) && (window == pat_q) &&
                 !bus.pat_load && !rst;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            fill_d = '0;
        end else if (bus.in_valid) begin
            if (match && !OVERLAP) begin
                fill_d = '0;
            end else begin
                hist_d = HistW'(window);
                if (fill_q != FillFull) begin
                    fill_d = fill_q + FillW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = StFilling;
        if (fill_d == '0) begin
            state_d = StEmpty;
        end else if (fill_d == FillFull) begin
            state_d = StArmed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= RST_PAT;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= StEmpty;
            match_r_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            match_r_q <= match;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (match),
        .clr_i   (bus.cnt_clr),
        .count_o (bus.match_count)
    );

    assign bus.match   = match;
    assign bus.match_r = match_r_q;
    assign bus.armed   = (state_q == StArmed);

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: an overlapping and a non-overlapping detector share one stimulus stream;
// the driver queues hand-computed expectations, a negedge monitor pops and compares them.
module tb_seq_detector_param;

    typedef struct packed {
        logic       chk;
        logic       em_o;
        logic       em_n;
        logic [1:0] ec_o;
        logic [1:0] ec_n;
        logic       ea_o;
        logic       ea_n;
        logic       emr_o;
        logic       emr_n;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       pat_load;
    logic [2:0] pat_in;
    logic       in_valid;
    logic       data_in;
    logic       cnt_clr;

    int total;
    int bad;
    int n_item;
    exp_t sb[$];

    seq_detector_param_if #(.PAT_LEN(3), .CNT_W(2)) bus_o ();
    seq_detector_param_if #(.PAT_LEN(3), .CNT_W(2)) bus_n ();

    assign bus_o.pat_load = pat_load;
    assign bus_o.pat_in   = pat_in;
    assign bus_o.in_valid = in_valid;
    assign bus_o.data_in  = data_in;
    assign bus_o.cnt_clr  = cnt_clr;
    assign bus_n.pat_load = pat_load;
    assign bus_n.pat_in   = pat_in;
    assign bus_n.in_valid = in_valid;
    assign bus_n.data_in  = data_in;
    assign bus_n.cnt_clr  = cnt_clr;

    seq_detector_param #(.PAT_LEN(3), .OVERLAP(1'b1), .CNT_W(2)) dut_o (
        .clk (clk),
        .rst (rst),
        .bus (bus_o)
    );

    seq_detector_param #(.PAT_LEN(3), .OVERLAP(1'b0), .CNT_W(2)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t m(input logic eo, input logic en);
        exp_t e;
        e      = '0;
        e.em_o = eo;
        e.em_n = en;
        return e;
    endfunction

    function automatic exp_t s(input logic [1:0] co, input logic [1:0] cn, input logic ao,
                               input logic an, input logic mro, input logic mrn);
        exp_t e;
        e       = '0;
        e.chk   = 1'b1;
        e.ec_o  = co;
        e.ec_n  = cn;
        e.ea_o  = ao;
        e.ea_n  = an;
        e.emr_o = mro;
        e.emr_n = mrn;
        return e;
    endfunction

    task automatic cyc(input logic v, input logic d, input logic pl, input logic [2:0] pi,
                       input logic cc, input logic r, input exp_t e);
        @(posedge clk);
        #1;
        in_valid = v;
        data_in  = d;
        pat_load = pl;
        pat_in   = pi;
        cnt_clr  = cc;
        rst      = r;
        sb.push_back(e);
    endtask

    task automatic bit_in(input logic d, input logic eo, input logic en);
        cyc(1'b1, d, 1'b0, 3'b000, 1'b0, 1'b0, m(eo, en));
    endtask

    task automatic clr_bit(input logic d, input logic eo, input logic en);
        cyc(1'b1, d, 1'b0, 3'b000, 1'b1, 1'b0, m(eo, en));
    endtask

    task automatic idle(input logic d);
        cyc(1'b0, d, 1'b0, 3'b000, 1'b0, 1'b0, m(1'b0, 1'b0));
    endtask

    // Loads are issued with a valid '1' on the wire to show the forced-off match.
    task automatic load(input logic [2:0] p, input logic cc);
        cyc(1'b1, 1'b1, 1'b1, p, cc, 1'b0, m(1'b0, 1'b0));
    endtask

    task automatic rst_cyc();
        cyc(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, m(1'b0, 1'b0));
    endtask

    task automatic chk(input logic [1:0] co, input logic [1:0] cn, input logic ao,
                       input logic an, input logic mro, input logic mrn);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, s(co, cn, ao, an, mro, mrn));
    endtask

    task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s item %0d: got %0d expected %0d", name, n_item, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("match_ovl", {1'b0, bus_o.match}, {1'b0, e.em_o});
                cmp("match_novl", {1'b0, bus_n.match}, {1'b0, e.em_n});
                if (e.chk) begin
                    cmp("count_ovl", bus_o.match_count, e.ec_o);
                    cmp("count_novl", bus_n.match_count, e.ec_n);
                    cmp("armed_ovl", {1'b0, bus_o.armed}, {1'b0, e.ea_o});
                    cmp("armed_novl", {1'b0, bus_n.armed}, {1'b0, e.ea_n});
                    cmp("match_r_ovl", {1'b0, bus_o.match_r}, {1'b0, e.emr_o});
                    cmp("match_r_novl", {1'b0, bus_n.match_r}, {1'b0, e.emr_n});
                end
                n_item++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: sim time expired, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        total    = 0;
        bad      = 0;
        n_item   = 0;
        rst      = 1'b1;
        pat_load = 1'b0;
        pat_in   = 3'b000;
        in_valid = 1'b0;
        data_in  = 1'b0;
        cnt_clr  = 1'b0;

        rst_cyc();
        rst_cyc();
        chk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        load(3'b101, 1'b0);

        // 1,0,1,0,1 then 0,1: overlap hits bits 3,5,7; non-overlap hits 3 and 7
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b1, 1'b1);
        chk(2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b1, 1'b0);
        chk(2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b1, 1'b1);
        chk(2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1);

        // valid gaps with junk data; overlap counter is saturated at 3
        bit_in(1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b1, 1'b1);
        chk(2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1);

        // run-time reload to 110 mid-sequence
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        chk(2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        load(3'b110, 1'b0);
        chk(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b1, 1'b1);
        chk(2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);

        // clear coinciding with a match wins, then counting resumes from 0
        bit_in(1'b1, 1'b0, 1'b0);
        clr_bit(1'b0, 1'b1, 1'b1);
        chk(2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b1, 1'b1);
        chk(2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);

        // reset mid-sequence: armed 10 + valid 1 under rst must not match; pattern reverts to 110
        load(3'b101, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        rst_cyc();
        chk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b1, 1'b1);
        chk(2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);

        // simultaneous load and clear, then a partial 1,0,0 under pattern 101
        load(3'b101, 1'b1);
        bit_in(1'b1, 1'b0, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        bit_in(1'b0, 1'b0, 1'b0);
        chk(2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
